// File: rtl/cla32_arbiter.sv
// Two-requester front end for a shared 32-bit carry look-ahead adder.
// A round-robin or fixed-priority grant selects one add/subtract request.
// A three-state FSM then runs the shared adder and returns a registered
// result with flags, plus a one-cycle ack to the winner.
module cla32_arbiter #(
  parameter int FAIR = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0,
  input  logic        op0,
  input  logic [31:0] a0,
  input  logic [31:0] b0,
  output logic        ack0,
  input  logic        req1,
  input  logic        op1,
  input  logic [31:0] a1,
  input  logic [31:0] b1,
  output logic        ack1,
  output logic [31:0] result,
  output logic        co,
  output logic        ovf,
  output logic        zero,
  output logic        valid,
  output logic        gnt_id
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t      state_q;
  logic [31:0] a_q, beff_q;
  logic        ci_q;
  logic        owner_q;
  logic        last_gnt_q;
  logic        win_d;
  logic [31:0] sum;
  logic [8:0]  c;

  // Winner for this IDLE edge; only meaningful when at least one req is up.
  always_comb begin
    win_d = 1'b0;
    if (req0 && req1) win_d = (FAIR != 0) ? ~last_gnt_q : 1'b0;
    else              win_d = req1;
  end

  // Adder sees only the latched operands, never the live requester buses.
  assign c[0] = ci_q;

  for (genvar k = 0; k < 8; k++) begin : g_grp
    logic [3:0] gg, pp;
    logic [4:0] cc;
    assign gg    = a_q[4*k +: 4] & beff_q[4*k +: 4];
    assign pp    = a_q[4*k +: 4] ^ beff_q[4*k +: 4];
    assign cc[0] = c[k];
    assign cc[1] = gg[0] | (pp[0] & cc[0]);
    assign cc[2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & cc[0]);
    assign cc[3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                 | (pp[2] & pp[1] & pp[0] & cc[0]);
    assign cc[4] = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
                 | (pp[3] & pp[2] & pp[1] & gg[0])
                 | (pp[3] & pp[2] & pp[1] & pp[0] & cc[0]);
    assign sum[4*k +: 4] = pp ^ cc[3:0];
    assign c[k+1]        = cc[4];
  end

  // Grant / execute / done sequencer with all outputs registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      a_q        <= '0;
      beff_q     <= '0;
      ci_q       <= 1'b0;
      owner_q    <= 1'b0;
      last_gnt_q <= 1'b1;
      result     <= '0;
      co         <= 1'b0;
      ovf        <= 1'b0;
      zero       <= 1'b0;
      valid      <= 1'b0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      gnt_id     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          valid <= 1'b0;
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          if (req0 || req1) begin
            a_q     <= win_d ? a1 : a0;
            beff_q  <= win_d ? (op1 ? ~b1 : b1) : (op0 ? ~b0 : b0);
            ci_q    <= win_d ? op1 : op0;
            owner_q <= win_d;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          result     <= sum;
          co         <= c[8];
          ovf        <= (a_q[31] == beff_q[31]) && (sum[31] != a_q[31]);
          zero       <= (sum == 32'd0);
          gnt_id     <= owner_q;
          last_gnt_q <= owner_q;
          valid      <= 1'b1;
          ack0       <= ~owner_q;
          ack1       <= owner_q;
          state_q    <= DONE;
        end
        DONE: begin
          valid   <= 1'b0;
          ack0    <= 1'b0;
          ack1    <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cla32_arbiter.sv
// Scoreboard bench for cla32_arbiter: a transaction-level model predicts
// grants and arithmetic results, a monitor compares on every valid.
module tb_cla32_arbiter;

  localparam int FAIR = 1;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req0 = 1'b0, op0 = 1'b0, req1 = 1'b0, op1 = 1'b0;
  logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic        ack0, ack1, co, ovf, zero, valid, gnt_id;
  logic [31:0] result;

  cla32_arbiter #(.FAIR(FAIR)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .op0(op0), .a0(a0), .b0(b0), .ack0(ack0),
    .req1(req1), .op1(op1), .a1(a1), .b1(b1), .ack1(ack1),
    .result(result), .co(co), .ovf(ovf), .zero(zero),
    .valid(valid), .gnt_id(gnt_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    bit          id;
    logic [31:0] res;
    bit          co, ovf, zero;
  } exp_t;

  exp_t        q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  bit          granted[2];
  bit          hold_chk = 1'b0;
  logic [31:0] last_res = '0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Expected response from plain integer arithmetic on the request.
  function automatic exp_t predict(input bit id, input bit op, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'(a);
    longint ub = longint'(b);
    longint sr = op ? sa - sb : sa + sb;
    e.id   = id;
    e.due  = 0;
    e.res  = op ? a - b : a + b;
    e.co   = op ? (ua >= ub) : ((ua + ub) >= 64'h1_0000_0000);
    e.ovf  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    e.zero = (e.res == 32'd0);
    return e;
  endfunction

  // Reference model: an operation occupies the adder for three cycles and
  // its result is due one cycle after the grant edge.
  initial begin
    int busy = 0;
    bit last = 1'b1;
    bit w;
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      if (!reset_n) begin
        busy = 0;
        last = 1'b1;
        q.delete();
      end else if (busy > 0) begin
        busy--;
      end else if (req0 || req1) begin
        if (req0 && req1) w = FAIR ? !last : 1'b0;
        else              w = req1;
        e = w ? predict(1'b1, op1, a1, b1) : predict(1'b0, op0, a0, b0);
        e.due = cyc + 1;
        q.push_back(e);
        granted[w] = 1'b1;
        last = w;
        busy = 2;
      end
    end
  end

  // Monitor: compares every presented result against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        last_res = '0;
        check("reset_outputs", {result, co, ovf, zero, valid, ack0, ack1, gnt_id}, 64'd0);
      end else if (valid) begin
        if (q.size() == 0) begin
          fail("unexpected_valid");
        end else begin
          e = q.pop_front();
          check("valid_cycle", cyc, e.due);
          check("result", result, e.res);
          check("co", co, e.co);
          check("ovf", ovf, e.ovf);
          check("zero", zero, e.zero);
          check("gnt_id", gnt_id, e.id);
          check("ack0", ack0, !e.id);
          check("ack1", ack1, e.id);
          last_res = e.res;
        end
      end else begin
        if (ack0 || ack1) fail("ack_without_valid");
        if (hold_chk) check("idle_hold_result", result, last_res);
        if (q.size() > 0 && q[0].due <= cyc) begin
          fail("missing_valid");
          void'(q.pop_front());
        end
      end
    end
  end

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 4))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic set_req(input int i, input bit r, input bit op, input logic [31:0] a, input logic [31:0] b);
    if (i == 0) begin req0 = r; op0 = op; a0 = a; b0 = b; end
    else        begin req1 = r; op1 = op; a1 = a; b1 = b; end
  endtask

  // Issue one request, hold it until ack, optionally scramble after grant.
  task automatic run_one(input int i, input bit op, input logic [31:0] a, input logic [31:0] b, input bit scr);
    int t = 0;
    bit done = 1'b0;
    granted[i] = 1'b0;
    set_req(i, 1'b1, op, a, b);
    while (!done && t < 60) begin
      @(negedge clk);
      if ((i == 0) ? ack0 : ack1) done = 1'b1;
      else begin
        @(posedge clk); #1; t++;
        if (scr && granted[i]) set_req(i, 1'b1, $urandom_range(0, 1), $urandom, $urandom);
      end
    end
    if (!done) fail($sformatf("ack_timeout_req%0d", i));
    @(posedge clk); #1;
    if (i == 0) req0 = 1'b0; else req1 = 1'b0;
  endtask

  task automatic rand_driver(input int i, input int n);
    repeat (n) begin
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      run_one(i, $urandom_range(0, 1), rnd_val(), rnd_val(), $urandom_range(0, 1));
    end
  endtask

  initial begin
    int t;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;

    // Single add wrapping to zero, then subtract with signed overflow.
    run_one(0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    run_one(1, 1'b1, 32'h8000_0000, 32'h0000_0001, 1'b0);

    // Both held high: grants alternate starting with requester 0.
    fork
      begin repeat (3) run_one(0, 1'b0, 32'd5, 32'd3, 1'b0); end
      begin repeat (3) run_one(1, 1'b1, 32'd10, 32'd4, 1'b0); end
    join

    // Inputs change right after grant; latched operands must be used.
    run_one(0, 1'b0, 32'h1234_5678, 32'h1111_1111, 1'b1);

    // Reset during EXEC: everything clears at once, no ack follows.
    granted[0] = 1'b0;
    set_req(0, 1'b1, 1'b0, 32'h0000_00AA, 32'h0000_0055);
    t = 0;
    while (!granted[0] && t < 20) begin @(posedge clk); #1; t++; end
    if (!granted[0]) fail("mid_reset_no_grant");
    reset_n = 1'b0;
    req0 = 1'b0;
    #1 check("mid_reset_immediate", {result, co, ovf, zero, valid, ack0, ack1, gnt_id}, 64'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (4) begin @(posedge clk); #1; end

    // Fresh tie after reset: requester 0 first.
    fork
      run_one(0, 1'b0, 32'h0000_0100, 32'h0000_0023, 1'b0);
      run_one(1, 1'b1, 32'h0000_0001, 32'h0000_0002, 1'b0);
    join

    // Idle: no requests, outputs hold.
    hold_chk = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    hold_chk = 1'b0;

    // Randomized contention.
    fork
      rand_driver(0, 20);
      rand_driver(1, 20);
    join
    repeat (6) begin @(posedge clk); #1; end
    check("scoreboard_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
